// File: rtl/muntjac_wfi_ctrl.sv
// muntjac_wfi_ctrl: WFI sleep sequencer between frontend and backend.
// Gates fetch on a retired WFI with no interrupt pending. It waits for the
// backend to drain, then requests the clock gate. On wake it issues a
// one-cycle redirect to the instruction after the WFI.
// Optional feature macro: MUNTJAC_WFI_STATS_EN enables a saturating
// 32-bit count of cycles spent in SLEEP on sleep_cycles_o.
module muntjac_wfi_ctrl #(
    parameter int unsigned DrainLimit = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wfi_valid_i,
    input  logic [63:0] wfi_next_pc_i,
    input  logic        pipe_idle_i,
    input  logic        irq_pending_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic        redirect_valid_o,
    output logic [63:0] redirect_pc_o,
    output logic        clock_gate_req_o,
    output logic        sleeping_o,
    output logic [31:0] sleep_cycles_o
);

    localparam int unsigned CntW = (DrainLimit > 1) ? $clog2(DrainLimit) : 1;
    localparam logic [CntW-1:0] DrainLast = CntW'(DrainLimit - 1);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StSleep = 2'd2;
    localparam logic [1:0] StWake  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [63:0]     pc_q, pc_d;
    logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic            clock_gate_q, clock_gate_d;
    logic            sleeping_q, sleeping_d;
    logic            fetch_open_c;

    // Next-state, latched PC, drain timer and state-decoded output flops
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drain_cnt_d = drain_cnt_q;

        case (state_q)
            StRun: begin
                // A WFI with an interrupt already pending behaves as a NOP
                if (wfi_valid_i && !irq_pending_i) begin
                    state_d     = StDrain;
                    pc_d        = wfi_next_pc_i;
                    drain_cnt_d = '0;
                end
            end
            StDrain: begin
                if (irq_pending_i) begin
                    state_d = StWake;
                end else if (pipe_idle_i) begin
                    state_d = StSleep;
                end else if (drain_cnt_q == DrainLast) begin
                    state_d = StWake;
                end else begin
                    drain_cnt_d = drain_cnt_q + CntW'(1);
                end
            end
            StSleep: begin
                if (irq_pending_i) begin
                    state_d = StWake;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        redirect_valid_d = (state_d == StWake);
        clock_gate_d     = (state_d == StSleep);
        sleeping_d       = (state_d != StRun);
    end

    // State register and registered outputs with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= StRun;
            pc_q             <= '0;
            drain_cnt_q      <= '0;
            redirect_valid_q <= 1'b0;
            clock_gate_q     <= 1'b0;
            sleeping_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            drain_cnt_q      <= drain_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            clock_gate_q     <= clock_gate_d;
            sleeping_q       <= sleeping_d;
        end
    end

    // Fetch handshake is gated combinationally so nothing transfers while closed
    assign fetch_open_c     = (state_q == StRun);
    assign fetch_ready_o    = fetch_ready_i & fetch_open_c;
    assign fetch_valid_o    = fetch_valid_i & fetch_open_c;

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = pc_q;
    assign clock_gate_req_o = clock_gate_q;
    assign sleeping_o       = sleeping_q;

`ifdef MUNTJAC_WFI_STATS_EN
    logic [31:0] sleep_cnt_q, sleep_cnt_d;

    // Saturating count of cycles spent in SLEEP
    always_comb begin
        sleep_cnt_d = sleep_cnt_q;
        if ((state_q == StSleep) && (sleep_cnt_q != 32'hFFFF_FFFF)) begin
            sleep_cnt_d = sleep_cnt_q + 32'd1;
        end
    end

    // Sleep counter register, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sleep_cnt_q <= '0;
        end else begin
            sleep_cnt_q <= sleep_cnt_d;
        end
    end

    assign sleep_cycles_o = sleep_cnt_q;
`else
    assign sleep_cycles_o = '0;
`endif

endmodule

// File: tb/tb_muntjac_wfi_ctrl.sv
// tb_muntjac_wfi_ctrl: directed self-checking bench for muntjac_wfi_ctrl.
module tb_muntjac_wfi_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        wfi_valid_i;
    logic [63:0] wfi_next_pc_i;
    logic        pipe_idle_i;
    logic        irq_pending_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o;
    logic        clock_gate_req_o;
    logic        sleeping_o;
    logic [31:0] sleep_cycles_o;

    int asserts;
    int fails;

    localparam logic [63:0] Pc0 = 64'h0000_0000_8000_0104;
    localparam logic [63:0] Pc1 = 64'h0000_0000_8000_2000;

    muntjac_wfi_ctrl #(.DrainLimit(16)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .wfi_valid_i      (wfi_valid_i),
        .wfi_next_pc_i    (wfi_next_pc_i),
        .pipe_idle_i      (pipe_idle_i),
        .irq_pending_i    (irq_pending_i),
        .fetch_valid_i    (fetch_valid_i),
        .fetch_ready_o    (fetch_ready_o),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_ready_i    (fetch_ready_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .clock_gate_req_o (clock_gate_req_o),
        .sleeping_o       (sleeping_o),
        .sleep_cycles_o   (sleep_cycles_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        wfi_valid_i = 1'b0; wfi_next_pc_i = '0; pipe_idle_i = 1'b0;
        irq_pending_i = 1'b0; fetch_valid_i = 1'b1; fetch_ready_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        asserts++;
        if (sleeping_o !== 1'b0) begin fails++; $display("FAIL reset_sleeping got=%b exp=0", sleeping_o); end
        asserts++;
        if (redirect_valid_o !== 1'b0) begin fails++; $display("FAIL reset_redirect got=%b exp=0", redirect_valid_o); end
        asserts++;
        if (clock_gate_req_o !== 1'b0) begin fails++; $display("FAIL reset_gate got=%b exp=0", clock_gate_req_o); end
        asserts++;
        if (redirect_pc_o !== 64'd0) begin fails++; $display("FAIL reset_pc got=%h exp=0", redirect_pc_o); end
        asserts++;
        if (sleep_cycles_o !== 32'd0) begin fails++; $display("FAIL reset_stats got=%0d exp=0", sleep_cycles_o); end
        asserts++;
        if (fetch_ready_o !== 1'b1 || fetch_valid_o !== 1'b1) begin
            fails++; $display("FAIL reset_fetch got rdy=%b vld=%b exp 1/1", fetch_ready_o, fetch_valid_o);
        end
        fetch_ready_i = 1'b0; fetch_valid_i = 1'b0;
        #1;
        asserts++;
        if (fetch_ready_o !== 1'b0 || fetch_valid_o !== 1'b0) begin
            fails++; $display("FAIL reset_fetch_follow got rdy=%b vld=%b exp 0/0", fetch_ready_o, fetch_valid_o);
        end
        fetch_ready_i = 1'b1; fetch_valid_i = 1'b1;
    endtask

    task automatic test_wfi_irq_nop();
        wfi_valid_i = 1'b1; wfi_next_pc_i = Pc0; irq_pending_i = 1'b1;
        tick();
        wfi_valid_i = 1'b0; irq_pending_i = 1'b0;
        asserts++;
        if (sleeping_o !== 1'b0) begin fails++; $display("FAIL nop_sleeping got=%b exp=0", sleeping_o); end
        asserts++;
        if (fetch_ready_o !== 1'b1 || fetch_valid_o !== 1'b1) begin
            fails++; $display("FAIL nop_fetch got rdy=%b vld=%b exp 1/1", fetch_ready_o, fetch_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if (redirect_valid_o !== 1'b0) begin fails++; $display("FAIL nop_redirect cyc=%0d got=%b exp=0", i, redirect_valid_o); end
            tick();
        end
    endtask

    task automatic test_sleep_wake();
        // Cycle N: WFI retires
        wfi_valid_i = 1'b1; wfi_next_pc_i = Pc0;
        asserts++;
        if (fetch_ready_o !== 1'b1) begin fails++; $display("FAIL sw_fetch_n got=%b exp=1", fetch_ready_o); end
        tick();
        // N+1: DRAIN, fetch gated
        wfi_valid_i = 1'b0; wfi_next_pc_i = '0; pipe_idle_i = 1'b1;
        asserts++;
        if (sleeping_o !== 1'b1 || clock_gate_req_o !== 1'b0) begin
            fails++; $display("FAIL sw_drain got slp=%b gate=%b exp 1/0", sleeping_o, clock_gate_req_o);
        end
        asserts++;
        if (fetch_ready_o !== 1'b0 || fetch_valid_o !== 1'b0) begin
            fails++; $display("FAIL sw_gated got rdy=%b vld=%b exp 0/0", fetch_ready_o, fetch_valid_o);
        end
        tick();
        pipe_idle_i = 1'b0;
        // N+2..N+5: SLEEP
        for (int i = 2; i <= 5; i++) begin
            if (i == 5) irq_pending_i = 1'b1;
            asserts++;
            if (clock_gate_req_o !== 1'b1 || redirect_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
                fails++; $display("FAIL sw_sleep N+%0d got gate=%b redir=%b rdy=%b exp 1/0/0",
                                  i, clock_gate_req_o, redirect_valid_o, fetch_ready_o);
            end
            tick();
        end
        // N+6: WAKE
        irq_pending_i = 1'b0;
        asserts++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== Pc0) begin
            fails++; $display("FAIL sw_wake got v=%b pc=%h exp 1/%h", redirect_valid_o, redirect_pc_o, Pc0);
        end
        asserts++;
        if (clock_gate_req_o !== 1'b0 || sleeping_o !== 1'b1 || fetch_ready_o !== 1'b0) begin
            fails++; $display("FAIL sw_wake_misc got gate=%b slp=%b rdy=%b exp 0/1/0",
                              clock_gate_req_o, sleeping_o, fetch_ready_o);
        end
        tick();
        // N+7: RUN
        asserts++;
        if (redirect_valid_o !== 1'b0 || sleeping_o !== 1'b0 || fetch_ready_o !== 1'b1 || fetch_valid_o !== 1'b1) begin
            fails++; $display("FAIL sw_run got redir=%b slp=%b rdy=%b vld=%b exp 0/0/1/1",
                              redirect_valid_o, sleeping_o, fetch_ready_o, fetch_valid_o);
        end
`ifdef MUNTJAC_WFI_STATS_EN
        asserts++;
        if (sleep_cycles_o !== 32'd4) begin fails++; $display("FAIL sw_stats got=%0d exp=4", sleep_cycles_o); end
`else
        asserts++;
        if (sleep_cycles_o !== 32'd0) begin fails++; $display("FAIL sw_stats got=%0d exp=0", sleep_cycles_o); end
`endif
    endtask

    task automatic test_drain_timeout();
        wfi_valid_i = 1'b1; wfi_next_pc_i = Pc1; pipe_idle_i = 1'b0;
        tick();
        wfi_valid_i = 1'b0; wfi_next_pc_i = '0;
        // Entered DRAIN; 15 more cycles stay in DRAIN
        for (int i = 0; i < 16; i++) begin
            // A second WFI while draining must not relatch the PC
            if (i == 5) begin wfi_valid_i = 1'b1; wfi_next_pc_i = Pc0; end
            else begin wfi_valid_i = 1'b0; wfi_next_pc_i = '0; end
            asserts++;
            if (sleeping_o !== 1'b1 || redirect_valid_o !== 1'b0 || clock_gate_req_o !== 1'b0) begin
                fails++; $display("FAIL to_drain cyc=%0d got slp=%b redir=%b gate=%b exp 1/0/0",
                                  i, sleeping_o, redirect_valid_o, clock_gate_req_o);
            end
            tick();
        end
        wfi_valid_i = 1'b0;
        asserts++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== Pc1 || clock_gate_req_o !== 1'b0) begin
            fails++; $display("FAIL to_wake got v=%b pc=%h gate=%b exp 1/%h/0",
                              redirect_valid_o, redirect_pc_o, clock_gate_req_o, Pc1);
        end
        tick();
        asserts++;
        if (sleeping_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
            fails++; $display("FAIL to_run got slp=%b redir=%b exp 0/0", sleeping_o, redirect_valid_o);
        end
    endtask

    task automatic test_irq_idle_same_cycle();
        wfi_valid_i = 1'b1; wfi_next_pc_i = Pc0;
        tick();
        wfi_valid_i = 1'b0; irq_pending_i = 1'b1; pipe_idle_i = 1'b1;
        tick();
        irq_pending_i = 1'b0; pipe_idle_i = 1'b0;
        asserts++;
        if (redirect_valid_o !== 1'b1 || clock_gate_req_o !== 1'b0) begin
            fails++; $display("FAIL prio got redir=%b gate=%b exp 1/0", redirect_valid_o, clock_gate_req_o);
        end
        tick();
        asserts++;
        if (sleeping_o !== 1'b0) begin fails++; $display("FAIL prio_run got slp=%b exp 0", sleeping_o); end
    endtask

    task automatic test_reset_in_sleep();
        wfi_valid_i = 1'b1; wfi_next_pc_i = Pc1;
        tick();
        wfi_valid_i = 1'b0; pipe_idle_i = 1'b1;
        tick();
        pipe_idle_i = 1'b0;
        asserts++;
        if (clock_gate_req_o !== 1'b1) begin fails++; $display("FAIL rs_presleep got=%b exp=1", clock_gate_req_o); end
        tick();
        rst_i = 1'b1; irq_pending_i = 1'b1;
        tick();
        rst_i = 1'b0; irq_pending_i = 1'b0;
        asserts++;
        if (sleeping_o !== 1'b0 || clock_gate_req_o !== 1'b0 || redirect_valid_o !== 1'b0 ||
            redirect_pc_o !== 64'd0 || sleep_cycles_o !== 32'd0 || fetch_ready_o !== 1'b1) begin
            fails++; $display("FAIL rs_state got slp=%b gate=%b redir=%b pc=%h cnt=%0d rdy=%b exp 0/0/0/0/0/1",
                              sleeping_o, clock_gate_req_o, redirect_valid_o, redirect_pc_o, sleep_cycles_o, fetch_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if (redirect_valid_o !== 1'b0) begin fails++; $display("FAIL rs_noredir cyc=%0d got=%b exp=0", i, redirect_valid_o); end
            tick();
        end
    endtask

    // Sleep for exactly n cycles in SLEEP, then wake and return to RUN
    task automatic do_sleep(input int n);
        wfi_valid_i = 1'b1; wfi_next_pc_i = Pc0;
        tick();
        wfi_valid_i = 1'b0; pipe_idle_i = 1'b1;
        tick();
        pipe_idle_i = 1'b0;
        for (int i = 1; i < n; i++) tick();
        irq_pending_i = 1'b1;
        tick();
        irq_pending_i = 1'b0;
        tick();
    endtask

    task automatic test_stats();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        do_sleep(3);
`ifdef MUNTJAC_WFI_STATS_EN
        asserts++;
        if (sleep_cycles_o !== 32'd3) begin fails++; $display("FAIL stats_first got=%0d exp=3", sleep_cycles_o); end
`else
        asserts++;
        if (sleep_cycles_o !== 32'd0) begin fails++; $display("FAIL stats_first got=%0d exp=0", sleep_cycles_o); end
`endif
        do_sleep(7);
`ifdef MUNTJAC_WFI_STATS_EN
        asserts++;
        if (sleep_cycles_o !== 32'd10) begin fails++; $display("FAIL stats_total got=%0d exp=10", sleep_cycles_o); end
`else
        asserts++;
        if (sleep_cycles_o !== 32'd0) begin fails++; $display("FAIL stats_total got=%0d exp=0", sleep_cycles_o); end
`endif
    endtask

    initial begin
        asserts = 0;
        fails   = 0;
        test_reset();
        test_wfi_irq_nop();
        test_sleep_wake();
        test_drain_timeout();
        test_irq_idle_same_cycle();
        test_reset_in_sleep();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/muntjac_wfi_ctrl.md
# muntjac_wfi_ctrl

Sequences the Muntjac pipeline into and out of low-power sleep on WFI. It sits between frontend and backend on the fetch handshake. When the backend retires a WFI with no interrupt pending, it gates fetch, waits for the backend to drain, then asserts a clock-gate request. On a pending interrupt it issues a single-cycle frontend redirect to the instruction after the WFI and reopens fetch.

## Interface
Parameters:
- DrainLimit, default 16: maximum number of cycles spent in DRAIN before sleep is abandonned; range 2..255.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- wfi_valid_i  in  1  backend retires a WFI this cycle
- wfi_next_pc_i  in  64  PC of the instruction following the WFI; qualified by wfi_valid_i
- pipe_idle_i  in  1  backend has no in-flight instructions and no outstanding dcache access
- irq_pending_i  in  1  OR of (mip & mie), ignoring mstatus.MIE/SIE, per WFI wake semantics
- fetch_valid_i  in  1  frontend fetch_valid
- fetch_ready_o  out  1  ready to frontend: fetch_ready_i & fetch_open
- fetch_valid_o  out  1  valid to backend: fetch_valid_i & fetch_open
- fetch_ready_i  in  1  backend fetch_ready
- redirect_valid_o  out  1  wake redirect request; ORed into the backend redirect by the parent
- redirect_pc_o  out  64  wake redirect target
- clock_gate_req_o  out  1  request to the external clock gate; high only in SLEEP
- sleeping_o  out  1  high in DRAIN, SLEEP or WAKE
- sleep_cycles_o  out  32  cycles spent in SLEEP (see Configuration)

## Operation
- Fetch payload (fetched_instr_t) passes through the parent and is not routed through this block. fetch_open = (state == RUN).
- States: RUN, DRAIN, SLEEP, WAKE. The state register is Moore; all outputs except the fetch gating are decoded from registered state.
- RUN:
  - wfi_valid_i & irq_pending_i: WFI acts as a NOP. Stay in RUN, no redirect.
  - wfi_valid_i & ~irq_pending_i: latch wfi_next_pc_i into pc_q, clear drain_cnt, go to DRAIN.
- DRAIN:
  - irq_pending_i: go to WAKE. Interrupt has priority over idle.
  - else pipe_idle_i: go to SLEEP.
  - else drain_cnt == DrainLimit-1: go to WAKE (timeout; sleep abandoned).
  - else drain_cnt increments.
- SLEEP: clock_gate_req_o = 1. irq_pending_i moves to WAKE; otherwise stay.
- WAKE: redirect_valid_o = 1 and redirect_pc_o = pc_q for exactly one cycle, then unconditionally RUN.
- wfi_valid_i outside RUN is ignored.
- redirect_pc_o = pc_q at all times; meaningful only when redirect_valid_o is high.
- drain_cnt width is $clog2(DrainLimit). It never wraps because the timeout exit fires first.

## Timing
- Reset values: state = RUN, pc_q = 0, drain_cnt = 0, sleep counter = 0, redirect_valid_o = 0, clock_gate_req_o = 0, sleeping_o = 0. fetch_* follow their inputs.
- WFI retired at cycle N (no irq):
  - DRAIN at N+1; fetch gated from N+1.
  - If pipe_idle_i is high at N+1, SLEEP at N+2.
- irq_pending_i high in SLEEP at cycle M: WAKE at M+1 with redirect_valid_o high; RUN at M+2, when fetch reopens.
- Minimum sleep round trip is 4 cycles (N..M+2 with M = N+2).
- The fetch handshake is combinationally gated only. No transfer may complete while fetch_open = 0.
- Reset asserted in any state returns to RUN on the next edge. An in-progress WAKE redirect is dropped; the reset vector supersedes it.

## Configuration
- MUNTJAC_WFI_STATS_EN defined: a 32-bit counter increments each cycle in SLEEP and saturates at 0xFFFF_FFFF. It clears only on rst_i and drives sleep_cycles_o.
- Not defined: no counter is instantiated and sleep_cycles_o is tied to 0.

## Test plan
- WFI with irq_pending_i = 1, wfi_next_pc_i = 0x8000_0104:
  - state stays RUN, redirect_valid_o never rises, fetch never gated.
- WFI with pc 0x8000_0104, pipe_idle_i = 1 at N+1, irq at N+5:
  - DRAIN at N+1, clock_gate_req_o = 1 at N+2..N+5.
  - redirect_valid_o = 1 with pc 0x8000_0104 at N+6 only; fetch_ready_o follows fetch_ready_i again from N+7.
- DrainLimit = 16, pipe_idle_i held 0, no irq:
  - WAKE exactly 16 cycles after entering DRAIN, then redirect to the latched pc.
  - clock_gate_req_o never asserts.
- irq_pending_i and pipe_idle_i both rise in the same DRAIN cycle:
  - next state WAKE, not SLEEP.
- rst_i pulsed in SLEEP:
  - next cycle is RUN, all outputs at reset values, no redirect issued.
- With MUNTJAC_WFI_STATS_EN, two sleeps of 3 and 7 cycles:
  - sleep_cycles_o = 10.
- Without MUNTJAC_WFI_STATS_EN, same stimulus:
  - sleep_cycles_o = 0 throughout.
